// File: rtl/backprop_pkg.sv
// Purpose: shared constants and stack-entry type for the backprop gradient stack.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package backprop_pkg;

  // Q8.8 fixed point: number of fraction bits removed after a full product
  localparam int FRAC_BITS = 8;

  // Default vector geometry; the entry value field is sized from these, so a
  // non-default size/data_size on the top also needs these updated.
  localparam int DEF_DATA_SIZE = 16;
  localparam int DEF_SIZE      = 3;
  localparam int ENTRY_VALUE_W = DEF_SIZE * DEF_DATA_SIZE;

  typedef struct packed {
    logic [31:0]              layer;
    logic [31:0]              row;
    logic [ENTRY_VALUE_W-1:0] value;
  } stack_entry_t;

endpackage

// File: rtl/backprop_stack_fx_mul.sv
// Purpose: one signed Q8.8 multiply; BACKPROP_SATURATE_EN selects saturation, else wrap.
// Latency: combinational.
// Backpressure: none.
module fx_mul
  import backprop_pkg::*;
#(
  parameter int data_size = DEF_DATA_SIZE
) (
  input  logic signed [data_size-1:0] a,
  input  logic signed [data_size-1:0] b,
  output logic signed [data_size-1:0] y
);

  localparam int PW = 2 * data_size;

`ifdef BACKPROP_SATURATE_EN
  localparam logic signed [PW-1:0] SAT_MAX = {{(data_size+1){1'b0}}, {(data_size-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(data_size+1){1'b1}}, {(data_size-1){1'b0}}};
`endif

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  // Full-precision product, rescaled, then clamped or truncated to one element
  always_comb begin
    prod    = PW'(a) * PW'(b);
    shifted = prod >>> FRAC_BITS;
`ifdef BACKPROP_SATURATE_EN
    if (shifted > SAT_MAX) begin
      y = SAT_MAX[data_size-1:0];
    end else if (shifted < SAT_MIN) begin
      y = SAT_MIN[data_size-1:0];
    end else begin
      y = data_size'(shifted);
    end
`else
    y = data_size'(shifted);
`endif
  end

endmodule

// File: rtl/backprop_stack.sv
// Purpose: LIFO of per-row weight gradients (delta[row] * input activation); macro BACKPROP_SATURATE_EN.
// Latency: push/delta load take effect on the next edge; popped entry appears one cycle after the request.
// Backpressure: none; pushes to a full stack and pops of an empty stack are dropped.
module backprop_stack
  import backprop_pkg::*;
#(
  parameter int max_layer_size = 4,
  parameter int data_size      = DEF_DATA_SIZE,
  parameter int size           = DEF_SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [size*data_size-1:0] diff_act,
  input  logic [size*data_size-1:0] diff_dense,
  input  logic [size*data_size-1:0] diff_start,
  input  logic [size*data_size-1:0] diff_cost,
  input  logic [31:0]               current_input_layer,
  input  logic [31:0]               current_input_row,
  input  logic                      is_last_layer,
  input  logic                      start_new_layer,
  input  logic                      read_update_data,
  input  logic                      active_train,
  output logic [31:0]               update_weight_layer,
  output logic [31:0]               update_weight_row,
  output logic [size*data_size-1:0] update_weight_value,
  output logic                      is_update_weight
);

  localparam int DEPTH = max_layer_size * size;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int RW    = (size > 1) ? $clog2(size) : 1;
  localparam int VW    = size * data_size;

  stack_entry_t                mem [DEPTH];
  stack_entry_t                top_entry;
  logic [CW-1:0]               count;
  logic signed [data_size-1:0] delta      [size];
  logic signed [data_size-1:0] delta_next [size];
  logic signed [data_size-1:0] grad       [size];
  logic [VW-1:0]               grad_vec;
  logic signed [data_size-1:0] row_delta;
  logic [RW-1:0]               row_idx;
  logic                        row_ok;
  logic                        do_pop;
  logic                        do_load;
  logic                        do_push;

  // Element multipliers: delta load (cost or dense times act) and gradient row
  for (genvar i = 0; i < size; i++) begin : g_elem
    fx_mul #(.data_size(data_size)) u_delta_mul (
      .a (is_last_layer ? diff_cost[(size-i)*data_size-1 -: data_size]
                        : diff_dense[(size-i)*data_size-1 -: data_size]),
      .b (diff_act[(size-i)*data_size-1 -: data_size]),
      .y (delta_next[i])
    );
    fx_mul #(.data_size(data_size)) u_grad_mul (
      .a (row_delta),
      .b (diff_start[(size-i)*data_size-1 -: data_size]),
      .y (grad[i])
    );
    assign grad_vec[(size-i)*data_size-1 -: data_size] = grad[i];
  end

  // Request decode: a pop request blocks loads and pushes; load and push are exclusive
  always_comb begin
    row_ok    = current_input_row < 32'(size);
    row_idx   = RW'(current_input_row);
    row_delta = row_ok ? delta[row_idx] : '0;
    do_pop    = read_update_data && (count != '0);
    do_load   = !read_update_data && active_train && start_new_layer;
    do_push   = !read_update_data && active_train && !start_new_layer &&
                row_ok && (count < CW'(DEPTH));
    top_entry = mem[AW'(count - 1'b1)];
  end

  // Entry storage; validity is tracked by count, so no reset is needed here
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[AW'(count)] <= '{layer: current_input_layer,
                           row:   current_input_row,
                           value: grad_vec};
    end
  end

  // Stack pointer, delta register and registered pop outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count               <= '0;
      update_weight_layer <= '0;
      update_weight_row   <= '0;
      update_weight_value <= '0;
      is_update_weight    <= 1'b0;
      for (int i = 0; i < size; i++) begin
        delta[i] <= '0;
      end
    end else begin
      is_update_weight <= do_pop;
      if (do_pop) begin
        count               <= count - 1'b1;
        update_weight_layer <= top_entry.layer;
        update_weight_row   <= top_entry.row;
        update_weight_value <= top_entry.value;
      end else if (do_push) begin
        count <= count + 1'b1;
      end
      if (do_load) begin
        for (int i = 0; i < size; i++) begin
          delta[i] <= delta_next[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_backprop_stack.sv
// Purpose: self-checking bench for backprop_stack (default parameters) with a queue-based model.
// Latency: model predicts registered pop outputs one cycle after each request.
// Backpressure: n/a.
module tb_backprop_stack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] diff_act, diff_dense, diff_start, diff_cost;
  logic [31:0] current_input_layer, current_input_row;
  logic        is_last_layer, start_new_layer, read_update_data, active_train;
  logic [31:0] update_weight_layer, update_weight_row;
  logic [47:0] update_weight_value;
  logic        is_update_weight;

  always #5 clk = ~clk;

  backprop_stack dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .diff_act            (diff_act),
    .diff_dense          (diff_dense),
    .diff_start          (diff_start),
    .diff_cost           (diff_cost),
    .current_input_layer (current_input_layer),
    .current_input_row   (current_input_row),
    .is_last_layer       (is_last_layer),
    .start_new_layer     (start_new_layer),
    .read_update_data    (read_update_data),
    .active_train        (active_train),
    .update_weight_layer (update_weight_layer),
    .update_weight_row   (update_weight_row),
    .update_weight_value (update_weight_value),
    .is_update_weight    (is_update_weight)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] layer;
    logic [31:0] row;
    logic [47:0] value;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] md [3];
  logic        m_vld;
  logic [31:0] m_layer, m_row;
  logic [47:0] m_value;

  function automatic logic [15:0] mulq(logic [15:0] a, logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 8;
`ifdef BACKPROP_SATURATE_EN
    if (p > 32767)  return 16'h7FFF;
    if (p < -32768) return 16'h8000;
`endif
    return p[15:0];
  endfunction

  function automatic logic [15:0] el(logic [47:0] v, int i);
    return v[(2-i)*16 +: 16];
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 3; i++) md[i] = '0;
    m_vld = 1'b0; m_layer = '0; m_row = '0; m_value = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_vld = 1'b0;
      if (read_update_data) begin
        if (mq.size() > 0) begin
          ent_t e;
          e = mq.pop_back();
          m_vld = 1'b1; m_layer = e.layer; m_row = e.row; m_value = e.value;
        end
      end else if (active_train) begin
        if (start_new_layer) begin
          for (int i = 0; i < 3; i++)
            md[i] = mulq(is_last_layer ? el(diff_cost, i) : el(diff_dense, i), el(diff_act, i));
        end else if (current_input_row < 3 && mq.size() < 12) begin
          ent_t e;
          e.layer = current_input_layer;
          e.row   = current_input_row;
          for (int j = 0; j < 3; j++)
            e.value[(2-j)*16 +: 16] = mulq(md[current_input_row], el(diff_start, j));
          mq.push_back(e);
        end
      end
    end
    #1;
    check("model_vld",   is_update_weight,    m_vld);
    check("model_layer", update_weight_layer, m_layer);
    check("model_row",   update_weight_row,   m_row);
    check("model_value", update_weight_value, m_value);
  endtask

  task automatic idle();
    active_train = 1'b0; read_update_data = 1'b0; start_new_layer = 1'b0;
  endtask

  function automatic logic [47:0] rnd_vec();
    logic [47:0] v;
    for (int i = 0; i < 3; i++) begin
      if ($urandom_range(0, 3) == 0) v[i*16 +: 16] = 16'($urandom);
      else v[i*16 +: 16] = 16'($signed(11'($urandom)));
    end
    return v;
  endfunction

  task automatic rnd_inputs();
    diff_act = rnd_vec(); diff_dense = rnd_vec(); diff_start = rnd_vec(); diff_cost = rnd_vec();
    current_input_layer = $urandom;
    current_input_row   = $urandom_range(0, 4);
    is_last_layer       = 1'($urandom);
    start_new_layer     = ($urandom_range(0, 7) == 0);
    read_update_data    = ($urandom_range(0, 2) == 0);
    active_train        = ($urandom_range(0, 3) != 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        last;
    logic [47:0] cost, dense, act, start;
    logic [31:0] layer, row;
    logic [47:0] exp_value;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nvalid;

    tbl[0] = '{1'b1, 48'h0200_0100_FF00, 48'h0000_0000_0000, 48'h0300_0100_0100,
               48'h0100_0200_0300, 32'd1, 32'd0, 48'h0600_0C00_1200};
    tbl[1] = '{1'b0, 48'h7F00_7F00_7F00, 48'h0080_FE00_0400, 48'h0200_0180_0040,
               48'h0100_FF00_0080, 32'd2, 32'd1, 48'hFD00_0300_FE80};
    tbl[2] = '{1'b1, 48'hFF80_0000_0100, 48'h1234_1234_1234, 48'h0400_0500_FE00,
               48'h0040_FF40_0200, 32'd3, 32'd2, 48'hFF80_0180_FC00};
`ifdef BACKPROP_SATURATE_EN
    tbl[3] = '{1'b1, 48'h7F00_0100_0100, 48'h0000_0000_0000, 48'h0100_0100_0100,
               48'h7F00_0100_8100, 32'd4, 32'd0, 48'h7FFF_7F00_8000};
`else
    tbl[3] = '{1'b1, 48'h7F00_0100_0100, 48'h0000_0000_0000, 48'h0100_0100_0100,
               48'h7F00_0100_8100, 32'd4, 32'd0, 48'h0100_7F00_FF00};
`endif

    // Reset with random inputs
    model_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rnd_inputs();
      tick();
      check("reset_vld",   is_update_weight,    0);
      check("reset_layer", update_weight_layer, 0);
      check("reset_value", update_weight_value, 0);
    end
    rst_n = 1'b1;
    idle();
    tick();

    // Table: load delta, push one row, pop it back
    for (int t = 0; t < 4; t++) begin
      active_train = 1'b1; start_new_layer = 1'b1; read_update_data = 1'b0;
      is_last_layer = tbl[t].last;
      diff_cost = tbl[t].cost; diff_dense = tbl[t].dense; diff_act = tbl[t].act;
      tick();
      start_new_layer = 1'b0;
      current_input_row = tbl[t].row; current_input_layer = tbl[t].layer;
      diff_start = tbl[t].start;
      tick();
      active_train = 1'b0; read_update_data = 1'b1;
      tick();
      check("tbl_vld",   is_update_weight,    1);
      check("tbl_layer", update_weight_layer, tbl[t].layer);
      check("tbl_row",   update_weight_row,   tbl[t].row);
      check("tbl_value", update_weight_value, tbl[t].exp_value);
      idle();
      tick();
    end

    // LIFO order
    active_train = 1'b1; start_new_layer = 1'b1; is_last_layer = 1'b1;
    diff_cost = tbl[0].cost; diff_act = tbl[0].act;
    tick();
    start_new_layer = 1'b0; current_input_layer = 32'd5; diff_start = tbl[0].start;
    for (int r = 0; r < 3; r++) begin
      current_input_row = r;
      tick();
    end
    active_train = 1'b0; read_update_data = 1'b1;
    for (int r = 2; r >= 0; r--) begin
      tick();
      check("lifo_vld", is_update_weight,  1);
      check("lifo_row", update_weight_row, r);
    end
    idle();
    tick();

    // Full / empty boundaries
    active_train = 1'b1; current_input_row = 32'd1;
    for (int k = 0; k < 13; k++) begin
      current_input_layer = k;
      tick();
    end
    active_train = 1'b0; read_update_data = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 13; k++) begin
      tick();
      if (is_update_weight) nvalid++;
      if (k == 0) check("full_top_layer", update_weight_layer, 11);
    end
    check("full_pop_count", nvalid, 12);
    check("empty_pop_vld",  is_update_weight, 0);
    tick();
    idle();

    // Reset mid-run discards entries
    active_train = 1'b1; current_input_row = 32'd0;
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    #2;
    check("async_rst_vld",   is_update_weight,    0);
    check("async_rst_value", update_weight_value, 0);
    check("async_rst_layer", update_weight_layer, 0);
    idle();
    tick();
    rst_n = 1'b1;
    read_update_data = 1'b1;
    tick();
    check("rst_pop_vld", is_update_weight, 0);
    idle();
    tick();

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rnd_inputs();
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
